// File: rtl/btb_pkg.sv
// Shared types and widths for the 2-way branch target buffer.
// Holds the 2-bit direction predictor encoding and its next-state rule.
// Pure definitions: no latency, no flow control.
`timescale 1ns/1ps
package btb_pkg;

    localparam int NUM_SETS = 8;
    localparam int WAYS     = 2;
    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_e;

    typedef struct packed {
        logic              vld;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        bp_state_e         state;
    } btb_entry_t;

    // Correct outcome saturates toward the current direction; a mispredict
    // takes one step toward the other direction.
    function automatic bp_state_e next_state(input bp_state_e state, input logic mispredicted);
        bp_state_e nxt;
        case (state)
            ST:      nxt = mispredicted ? WT  : ST;
            WT:      nxt = mispredicted ? WNT : ST;
            WNT:     nxt = mispredicted ? WT  : SNT;
            default: nxt = mispredicted ? WNT : SNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_predictor_fsm.sv
// Next-state logic for one 2-bit direction predictor entry.
// Combinational, zero latency.
// No flow control.
`timescale 1ns/1ps
module btb_predictor_fsm
    import btb_pkg::*;
(
    input  bp_state_e state_cur,
    input  logic      mispredicted,
    output bp_state_e state_nxt
);

    assign state_nxt = next_state(state_cur, mispredicted);

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative BTB: combinational lookup, synchronous train/allocate.
// Lookup zero latency; update visible the cycle after the strobe edge.
// No backpressure: one update accepted every cycle.
`timescale 1ns/1ps
module btb_2way #(
    parameter int NUM_SETS = btb_pkg::NUM_SETS,
    parameter int ADDR_W   = btb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    input  logic              update,
    input  logic [ADDR_W-1:0] updatePC,
    input  logic [ADDR_W-1:0] updateTarget,
    input  logic              mispredicted,
    output logic              valid,
    output logic [ADDR_W-1:0] target,
    output logic              predictedTaken
);
    import btb_pkg::*;

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TG_W  = ADDR_W - IDX_W - 2;

    typedef struct packed {
        logic              vld;
        logic [TG_W-1:0]   tag;
        logic [ADDR_W-1:0] target;
        bp_state_e         state;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{vld: 1'b0, tag: '0, target: '0, state: ST};

    entry_t [WAYS-1:0] ways_q [NUM_SETS];
    entry_t [WAYS-1:0] ways_d [NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;
    logic [NUM_SETS-1:0] lru_d;

    // Byte offset within the instruction word never participates.
    logic unused_lsb;
    assign unused_lsb = ^{PC[1:0], updatePC[1:0]};

    logic [IDX_W-1:0] rd_idx;
    logic [TG_W-1:0]  rd_tag;
    entry_t           rd_w0;
    entry_t           rd_w1;
    logic             rd_hit0;
    logic             rd_hit1;

    assign rd_idx  = PC[IDX_W+1:2];
    assign rd_tag  = PC[ADDR_W-1:IDX_W+2];
    assign rd_w0   = ways_q[rd_idx][0];
    assign rd_w1   = ways_q[rd_idx][1];
    assign rd_hit0 = rd_w0.vld && (rd_w0.tag == rd_tag);
    assign rd_hit1 = rd_w1.vld && (rd_w1.tag == rd_tag);

    always_comb begin
        valid          = 1'b0;
        target         = '0;
        predictedTaken = 1'b0;
        if (rd_hit0) begin
            valid          = 1'b1;
            target         = rd_w0.target;
            predictedTaken = rd_w0.state[1];
        end else if (rd_hit1) begin
            valid          = 1'b1;
            target         = rd_w1.target;
            predictedTaken = rd_w1.state[1];
        end
    end

    logic [IDX_W-1:0] wr_idx;
    logic [TG_W-1:0]  wr_tag;
    entry_t           wr_w0;
    entry_t           wr_w1;
    logic             wr_hit0;
    logic             wr_hit1;
    logic             wr_way;
    bp_state_e        cur_state;
    bp_state_e        trained_state;
    entry_t           wr_entry;

    assign wr_idx    = updatePC[IDX_W+1:2];
    assign wr_tag    = updatePC[ADDR_W-1:IDX_W+2];
    assign wr_w0     = ways_q[wr_idx][0];
    assign wr_w1     = ways_q[wr_idx][1];
    assign wr_hit0   = wr_w0.vld && (wr_w0.tag == wr_tag);
    assign wr_hit1   = wr_w1.vld && (wr_w1.tag == wr_tag);
    assign cur_state = wr_hit1 ? wr_w1.state : wr_w0.state;

    btb_predictor_fsm u_fsm (
        .state_cur    (cur_state),
        .mispredicted (mispredicted),
        .state_nxt    (trained_state)
    );

    // Hits train in place; misses fill an empty way first, else the LRU way.
    always_comb begin
        if (wr_hit0)         wr_way = 1'b0;
        else if (wr_hit1)    wr_way = 1'b1;
        else if (!wr_w0.vld) wr_way = 1'b0;
        else if (!wr_w1.vld) wr_way = 1'b1;
        else                 wr_way = lru_q[wr_idx];
    end

    always_comb begin
        wr_entry.vld    = 1'b1;
        wr_entry.tag    = wr_tag;
        wr_entry.target = updateTarget;
        wr_entry.state  = (wr_hit0 || wr_hit1) ? trained_state : ST;
    end

    always_comb begin
        ways_d = ways_q;
        lru_d  = lru_q;
        if (update) begin
            ways_d[wr_idx][wr_way] = wr_entry;
            lru_d[wr_idx]          = ~wr_way;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    ways_q[s][w] <= RESET_ENTRY;
                end
            end
            lru_q <= '0;
        end else begin
            ways_q <= ways_d;
            lru_q  <= lru_d;
        end
    end

endmodule

// File: tb/tb_btb_2way.sv
// Bench for btb_2way: directed scenarios plus randomized traffic against
// a recency-list reference model of each set.
`timescale 1ns/1ps
module tb_btb_2way;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        update;
    logic [31:0] updatePC;
    logic [31:0] updateTarget;
    logic        mispredicted;
    logic        valid;
    logic [31:0] target;
    logic        predictedTaken;

    int checks   = 0;
    int failures = 0;

    btb_2way dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .update         (update),
        .updatePC       (updatePC),
        .updateTarget   (updateTarget),
        .mispredicted   (mispredicted),
        .valid          (valid),
        .target         (target),
        .predictedTaken (predictedTaken)
    );

    always #5 clk = ~clk;

    // Reference: per set, up to two entries kept in most-recently-updated order.
    int          m_cnt [8];
    logic [26:0] m_tag [8][2];
    logic [31:0] m_tgt [8][2];
    int          m_ctr [8][2];

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) m_cnt[s] = 0;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt, input logic mis);
        int s;
        int hit_pos;
        logic [26:0] ht;
        logic [31:0] hg;
        int hc;
        s = int'(pc[4:2]);
        hit_pos = -1;
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == pc[31:5]) hit_pos = i;
        if (hit_pos >= 0) begin
            hc = m_ctr[s][hit_pos];
            if (!mis) hc = (hc >= 2) ? 3 : 0;
            else      hc = (hc >= 2) ? hc - 1 : hc + 1;
            ht = m_tag[s][hit_pos];
            if (hit_pos == 1) begin
                m_tag[s][1] = m_tag[s][0];
                m_tgt[s][1] = m_tgt[s][0];
                m_ctr[s][1] = m_ctr[s][0];
            end
            m_tag[s][0] = ht;
            m_tgt[s][0] = tgt;
            m_ctr[s][0] = hc;
        end else begin
            hg = tgt;
            m_tag[s][1] = m_tag[s][0];
            m_tgt[s][1] = m_tgt[s][0];
            m_ctr[s][1] = m_ctr[s][0];
            m_tag[s][0] = pc[31:5];
            m_tgt[s][0] = hg;
            m_ctr[s][0] = 3;
            if (m_cnt[s] < 2) m_cnt[s] = m_cnt[s] + 1;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic h, output logic [31:0] t, output logic p);
        int s;
        s = int'(pc[4:2]);
        h = 1'b0;
        t = 32'h0;
        p = 1'b0;
        for (int i = 0; i < m_cnt[s]; i++) begin
            if (m_tag[s][i] == pc[31:5]) begin
                h = 1'b1;
                t = m_tgt[s][i];
                p = (m_ctr[s][i] >= 2);
            end
        end
    endfunction

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic mis);
        @(negedge clk);
        updatePC     = pc;
        updateTarget = tgt;
        mispredicted = mis;
        update       = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        model_update(pc, tgt, mis);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        update = 1'b0;
        updatePC = 32'h0;
        updateTarget = 32'h0;
        mispredicted = 1'b0;
        PC = 32'h0;
        #12;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        PC           = 32'h000A0000;
        updatePC     = 32'h000A0000;
        updateTarget = 32'h000B0000;
        update       = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %0b want 0", valid);
        end
        checks++;
        if (target !== 32'h0) begin
            failures++;
            $display("FAIL reset_target: got %08h want 00000000", target);
        end
        checks++;
        if (predictedTaken !== 1'b0) begin
            failures++;
            $display("FAIL reset_taken: got %0b want 0", predictedTaken);
        end
    endtask

    task automatic test_allocate();
        do_update(32'h000A0000, 32'h000B0000, 1'b0);
        PC = 32'h000A0000;
        #1;
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B0000 || predictedTaken !== 1'b1) begin
            failures++;
            $display("FAIL alloc_hit: got v=%0b t=%08h p=%0b want v=1 t=000B0000 p=1", valid, target, predictedTaken);
        end
        // Low two PC bits must not matter.
        PC = 32'h000A0003;
        #1;
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B0000) begin
            failures++;
            $display("FAIL alloc_lsb_ignored: got v=%0b t=%08h want v=1 t=000B0000", valid, target);
        end
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        PC           = 32'h000A0010;
        updatePC     = 32'h000A0010;
        updateTarget = 32'h000B0010;
        mispredicted = 1'b0;
        update       = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass_pre: got v=%0b want 0", valid);
        end
        @(posedge clk);
        #1;
        update = 1'b0;
        model_update(32'h000A0010, 32'h000B0010, 1'b0);
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B0010) begin
            failures++;
            $display("FAIL no_bypass_post: got v=%0b t=%08h want v=1 t=000B0010", valid, target);
        end
    endtask

    task automatic test_training();
        logic mis_seq [6];
        logic exp_pt  [6];
        mis_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_pt  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_update(32'h000A0004, 32'h000B0004, 1'b0);
        PC = 32'h000A0004;
        for (int i = 0; i < 6; i++) begin
            do_update(32'h000A0004, 32'h000B0004, mis_seq[i]);
            #1;
            checks++;
            if (valid !== 1'b1 || predictedTaken !== exp_pt[i]) begin
                failures++;
                $display("FAIL train_step%0d: got v=%0b p=%0b want v=1 p=%0b", i, valid, predictedTaken, exp_pt[i]);
            end
        end
    endtask

    task automatic test_lru_alias();
        do_update(32'h000A000C, 32'h000B000C, 1'b0);
        do_update(32'h000A002C, 32'h000B002C, 1'b0);
        PC = 32'h000A000C;
        #1;
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B000C) begin
            failures++;
            $display("FAIL lru_first_hit: got v=%0b t=%08h want v=1 t=000B000C", valid, target);
        end
        PC = 32'h000A002C;
        #1;
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B002C) begin
            failures++;
            $display("FAIL lru_second_hit: got v=%0b t=%08h want v=1 t=000B002C", valid, target);
        end
        do_update(32'h000A004C, 32'h000B004C, 1'b1);
        PC = 32'h000A004C;
        #1;
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B004C || predictedTaken !== 1'b1) begin
            failures++;
            $display("FAIL lru_third_hit: got v=%0b t=%08h p=%0b want v=1 t=000B004C p=1", valid, target, predictedTaken);
        end
        PC = 32'h000A000C;
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL lru_evicted: got v=%0b want 0", valid);
        end
        PC = 32'h000A002C;
        #1;
        checks++;
        if (valid !== 1'b1 || target !== 32'h000B002C) begin
            failures++;
            $display("FAIL lru_survivor: got v=%0b t=%08h want v=1 t=000B002C", valid, target);
        end
    endtask

    task automatic test_isolation();
        logic [31:0] pc_s;
        for (int s = 0; s < 8; s++) begin
            pc_s = 32'h000A0000 + 32'(4 * s);
            do_update(pc_s, 32'h00C00000 + 32'(4 * s), 1'b0);
        end
        for (int s = 0; s < 8; s++) begin
            PC = 32'h000A0000 + 32'(4 * s);
            #1;
            checks++;
            if (valid !== 1'b1 || target !== 32'h00C00000 + 32'(4 * s)) begin
                failures++;
                $display("FAIL iso_set%0d: got v=%0b t=%08h want v=1 t=%08h", s, valid, target, 32'h00C00000 + 32'(4 * s));
            end
        end
        do_update(32'h000A0010, 32'h00D00010, 1'b0);
        for (int s = 3; s <= 5; s++) begin
            PC = 32'h000A0000 + 32'(4 * s);
            #1;
            checks++;
            if (valid !== 1'b1 || target !== ((s == 4) ? 32'h00D00010 : 32'h00C00000 + 32'(4 * s))) begin
                failures++;
                $display("FAIL iso_neighbour%0d: got v=%0b t=%08h", s, valid, target);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        PC           = 32'h000A0008;
        updatePC     = 32'h000A0008;
        updateTarget = 32'h00E00008;
        update       = 1'b1;
        rst          = 1'b1;
        #0.5;
        checks++;
        if (valid !== 1'b0 || target !== 32'h0 || predictedTaken !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_during: got v=%0b t=%08h p=%0b want 0 0 0", valid, target, predictedTaken);
        end
        #0.5;
        rst    = 1'b0;
        update = 1'b0;
        model_reset();
        for (int s = 0; s < 8; s++) begin
            PC = 32'h000A0000 + 32'(4 * s);
            #0.5;
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL async_rst_set%0d: got v=%0b want 0", s, valid);
            end
        end
    endtask

    task automatic test_random();
        logic        h;
        logic [31:0] t;
        logic        p;
        logic [31:0] upc;
        logic [31:0] utg;
        logic        umis;
        logic        uen;
        pulse_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            PC = 32'h00A00000 | (32'($urandom_range(0, 3)) << 5)
                 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            upc = 32'h00A00000 | (32'($urandom_range(0, 3)) << 5)
                  | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            utg  = $urandom;
            umis = 1'($urandom_range(0, 1));
            uen  = ($urandom_range(0, 9) < 7);
            updatePC     = upc;
            updateTarget = utg;
            mispredicted = umis;
            update       = uen;
            #1;
            model_lookup(PC, h, t, p);
            checks++;
            if (valid !== h || target !== t || predictedTaken !== p) begin
                failures++;
                $display("FAIL rand_lookup%0d pc=%08h: got v=%0b t=%08h p=%0b want v=%0b t=%08h p=%0b",
                         n, PC, valid, target, predictedTaken, h, t, p);
            end
            @(posedge clk);
            if (uen) model_update(upc, utg, umis);
        end
        #1;
        update = 1'b0;
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_no_bypass();
        test_training();
        test_lru_alias();
        test_isolation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_2way.md
Name: btb_2way

Overview:
- Branch Target Buffer for the RISC-V fetch stage.
- Set-associative: 8 sets, 2 ways, one 2-bit prediction FSM per entry.
- Lookup by fetch PC is combinational and returns hit, target and taken prediction.
- The execute stage trains or allocates entries through a synchronous update port.

Parameters:
- NUM_SETS, 8, number of sets; power of two; index = PC[2+log2(NUM_SETS)-1:2].
- ADDR_W, 32, PC and target width.
- Ways are fixed at 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- PC  in  32  fetch PC to look up.
- update  in  1  write/train strobe; sampled on the rising clk edge.
- updatePC  in  32  PC of the resolved branch.
- updateTarget  in  32  resolved branch target.
- mispredicted  in  1  resolved direction differed from this entry's prediction.
- valid  out  1  PC hits a valid entry.
- target  out  32  stored target of the hit entry.
- predictedTaken  out  1  MSB of the hit entry's FSM state.

Behaviour:
- Address split:
  - index = PC[4:2] (for NUM_SETS=8).
  - tag = PC[31:5].
  - PC[1:0] is ignored.
- Entry fields: valid bit, tag, 32-bit target, 2-bit state.
- Per-set state: one LRU bit naming the victim way.
- FSM encoding: 11 strong taken (ST), 10 weak taken (WT), 01 weak not-taken (WNT), 00 strong not-taken (SNT).
- Lookup (purely combinational, zero latency):
  - Hit when a way in set[index(PC)] is valid and its tag equals tag(PC).
  - On hit: valid=1, target=entry target, predictedTaken=state[1].
  - On miss: valid=0, target=0, predictedTaken=0.
  - Lookup never changes the LRU bit.
- Update (on the rising edge when update=1), index/tag taken from updatePC:
  - Hit in way w:
    - target := updateTarget.
    - state transitions as follows.
    - mispredicted=0 strengthens: ST->ST, WT->ST, WNT->SNT, SNT->SNT.
    - mispredicted=1 moves one step toward the opposite direction: ST->WT, WT->WNT, WNT->WT, SNT->WNT.
  - Miss, allocation:
    - Victim is the first invalid way (way0 before way1); if both ways are valid, victim = the way named by the LRU bit.
    - Victim gets valid=1, tag, target=updateTarget, state=ST.
    - mispredicted is ignored on allocation.
  - In both cases the LRU bit of the set is set to point at the way not just written; that way is now MRU.
- update=0: no state change.
- Simultaneous lookup and update of the same PC: lookup returns pre-edge contents (no bypass); the new contents are visible after the edge.
- Reset, asynchronous, any cycle including mid-update:
  - All valid bits=0, all LRU bits=0, all states=ST, targets/tags cleared.
  - Outputs therefore read valid=0, target=0, predictedTaken=0.

Decomposition:
- Package btb_pkg:
  - NUM_SETS, WAYS=2, INDEX_W, TAG_W.
  - FSM state enum (SNT, WNT, WT, ST).
  - Entry struct (valid, tag, target, state).
  - Function next_state(state, mispredicted).
- One natural sub-module, btb_predictor_fsm, implementing the combinational next-state function. Alternatively keep it as the package function.
- The top holds the arrays, hit/victim logic and LRU.

Test Plan:
- Reset, then update=0 with updatePC=0x000A0000; lookup PC=0x000A0000 -> valid=0.
- update=1, updatePC=0x000A0000, updateTarget=0x000B0000 for one edge; lookup same PC -> valid=1, target=0x000B0000, predictedTaken=1.
- Train PC 0x000A0004 (set1):
  - Two mispredicted updates -> predictedTaken 1 then 0 (ST->WT->WNT).
  - One further mispredict -> 1 (WT).
  - Two correct updates -> state ST.
- Set 3, aliasing/LRU:
  - Allocate 0x000A000C (target 0x000B000C), then 0x000A002C (target 0x000B002C); both hit.
  - Allocate 0x000A004C (target 0x000B004C) -> hits with target 0x000B004C.
  - 0x000A000C now misses (evicted LRU), 0x000A002C still hits.
- Isolation: fill every set 0..7 with PC=0x000A0000+4s; each lookup returns its own target; writes to set s never disturb set s±1.
- Assert rst for 1 ns mid-cycle after entries are populated -> valid=0 immediately for all previously hit PCs, with no clock edge needed.
